// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: opcode constants, fetch FSM states and reset defaults for the fetch unit.
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_pc_next_sel.sv
// pc_next_sel: next-PC mux; jump beats a taken branch, otherwise fall through to pc+4.
module pc_next_sel
    import inst_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] next_pc
);

    always_comb
        next_pc = jump  ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                  pcsrc ? pc_plus4 + branch_offset(instr[15:0]) :
                          pc_plus4;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner and FETCH/WAIT/ISSUE fetch FSM for a variable-latency imem.
// FETCH_TIMEOUT_EN adds a WAIT watchdog that reissues the fetch and sets sticky fetch_err.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
`ifdef FETCH_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        stall,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    state_t      state;
    logic [31:0] next_pc;

    // Gated by rst so no request escapes while the reset is still held.
    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;
    assign op        = instr[31:26];
    assign funct     = instr[5:0];
    assign pc_plus4  = pc + 32'd4;

    pc_next_sel u_pc_next_sel (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .pcsrc    (pcsrc),
        .jump     (jump),
        .next_pc  (next_pc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= PC_RESET;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt         <= '0;
            fetch_err   <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: state <= WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
`ifdef FETCH_TIMEOUT_EN
                        cnt         <= '0;
                    end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        fetch_err   <= 1'b1;
                        cnt         <= '0;
                        state       <= FETCH;
                    end else begin
                        cnt         <= cnt + 1'b1;
`endif
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed plus randomized checks of the fetch unit against a transaction-level model.
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_rvalid = 1'b0;
    logic        stall = 1'b0;
    logic        pcsrc = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .stall       (stall),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_err   (fetch_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: a request is due, a request is outstanding, or an instruction is presented.
    logic [31:0] m_pc, m_instr;
    bit          m_req, m_wait, m_valid, m_err;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next_pc();
        int off;
        off = int'($signed(m_instr[15:0]));
        if (jump) return ((m_pc + 32'd4) & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
        if (pcsrc) return m_pc + 32'd4 + 32'(off * 4);
        return m_pc + 32'd4;
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_instr = 32'd0; m_valid = 0; m_req = 1; m_wait = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        if (rst) model_reset();
        else if (m_req) begin
            m_req = 0; m_wait = 1; m_cnt = 0;
        end else if (m_wait) begin
            if (imem_rvalid) begin
                m_instr = imem_rdata; m_wait = 0; m_valid = 1;
            end
`ifdef FETCH_TIMEOUT_EN
            else begin
                m_cnt++;
                if (m_cnt == 16) begin
                    m_err = 1; m_wait = 0; m_req = 1;
                end
            end
`endif
        end else if (m_valid && !stall) begin
            m_pc = model_next_pc(); m_valid = 0; m_req = 1;
        end
    endtask

    task automatic compare_all();
        chk("imem_req", imem_req, m_req && !rst);
        if (m_req && !rst) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, m_valid);
        chk("instr", instr, m_instr);
        chk("op", op, m_instr[31:26]);
        chk("funct", funct, m_instr[5:0]);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("fetch_err", fetch_err, m_err);
    endtask

    task automatic cyc(input bit r, input bit rv, input logic [31:0] rd, input bit st, input bit ps, input bit jp);
        rst = r; imem_rvalid = rv; imem_rdata = rd; stall = st; pcsrc = ps; jump = jp;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input bit ps, input bit jp, input int nstall);
        chk("lit_req", imem_req, 1'b1);
        chk("lit_addr", imem_addr, addr);
        cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        cyc(0, 1, word, 0, 0, 0);
        chk("lit_valid", instr_valid, 1'b1);
        chk("lit_instr", instr, word);
        repeat (nstall) begin
            cyc(0, 1, ~word, 1, ps, jp);
            chk("lit_stall_instr", instr, word);
            chk("lit_stall_pc", pc, addr);
            chk("lit_stall_req", imem_req, 1'b0);
            chk("lit_stall_valid", instr_valid, 1'b1);
        end
        cyc(0, 0, 32'd0, 0, ps, jp);
    endtask

    initial begin
        logic [31:0] w;
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        #1;
        chk("lit_first_req", imem_req, 1'b1);
        chk("lit_first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) fetch(32'(i * 4), 32'd0, 0, 0, 0);
        // Reset in the middle of a pending fetch.
        cyc(0, 0, 32'd0, 0, 0, 0);
        cyc(0, 0, 32'd0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("lit_rst_pc", pc, 32'h0);
        chk("lit_rst_valid", instr_valid, 1'b0);
        chk("lit_rst_req", imem_req, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        #1;
        chk("lit_rel_req", imem_req, 1'b1);
        chk("lit_rel_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) fetch(32'(i * 4), 32'd0, 0, 0, 0);
        fetch(32'h10, 32'h1000_FFFE, 1, 0, 5);
        fetch(32'h0C, 32'h0800_0040, 1, 1, 0);
        fetch(32'h100, 32'h1000_FFBE, 1, 0, 0);
        chk("lit_wrap_plus4", pc_plus4, 32'h0);
        fetch(32'hFFFF_FFFC, 32'd0, 0, 0, 0);
        fetch(32'h0, 32'd0, 0, 0, 0);
`ifdef FETCH_TIMEOUT_EN
        chk("lit_err_clear", fetch_err, 1'b0);
        cyc(0, 0, 32'd0, 0, 0, 0);
        repeat (16) cyc(0, 0, 32'd0, 0, 0, 0);
        chk("lit_err_set", fetch_err, 1'b1);
        chk("lit_retry_req", imem_req, 1'b1);
        chk("lit_retry_addr", imem_addr, 32'h4);
`endif
        repeat (3000) begin
            w = $urandom;
            case ($urandom_range(0, 2))
                0: w[31:26] = OP_RTYPE;
                1: w[31:26] = OP_BEQ;
                default: w[31:26] = OP_J;
            endcase
            cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) == 0), w,
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        cyc(0, 0, 32'd0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
